pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_next_mux.sv | 37 +++
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU package: sequencer state encoding, fetch timeout default,
// instruction size and an alignment helper.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam int          TIMEOUT_DEFAULT = 15;
  localparam logic [31:0] INSTR_BYTES     = 32'd4;

  // Word-aligned fetch addresses only; low two bits must be zero.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC selection: pending redirect, then jump, then branch, else PC+4.
// Also flags when the chosen redirect target is not word aligned.
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pend_vld_i,
  input  logic [31:0] pend_tgt_i,
  input  logic        jump_valid_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] next_pc_o,
  output logic        redirect_o,
  output logic        misaligned_o
);

  logic [31:0] tgt;

  // Priority select; sequential fall-through wraps modulo 2^32 by width.
  always_comb begin
    tgt        = pc_i + INSTR_BYTES;
    redirect_o = 1'b1;
    if (pend_vld_i) begin
      tgt = pend_tgt_i;
    end else if (jump_valid_i) begin
      tgt = jump_target_i;
    end else if (branch_valid_i) begin
      tgt = branch_target_i;
    end else begin
      redirect_o = 1'b0;
    end
    next_pc_o    = tgt;
    misaligned_o = redirect_o && !is_aligned(tgt);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots from startPC, issues one fetch per ack,
// applies jump/branch redirects, stalls in HOLD, and parks in HALT or FAULT
// until reset.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        MasterReset,
  input  logic [31:0] startPC,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  input  logic        fetch_ack,
  output logic [31:0] PC,
  output logic        fetch_req,
  output logic        pc_valid,
  output logic        halted,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          pend_vld_q, pend_vld_d;
  logic [31:0]   pend_tgt_q, pend_tgt_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          pc_valid_d;
  logic          fetch_req_q, pc_valid_q, halted_q, fault_q;

  logic [31:0]   mux_next;
  logic          mux_redirect;
  logic          mux_misaligned;

  // Pending is only ever set while fetching, so HOLD sees plain jump/branch.
  pc_next_mux u_next_mux (
    .pc_i            (pc_q),
    .pend_vld_i      (pend_vld_q),
    .pend_tgt_i      (pend_tgt_q),
    .jump_valid_i    (jump_valid),
    .jump_target_i   (jump_target),
    .branch_valid_i  (branch_valid),
    .branch_target_i (branch_target),
    .next_pc_o       (mux_next),
    .redirect_o      (mux_redirect),
    .misaligned_o    (mux_misaligned)
  );

  // Next-state, next-PC, pending-redirect and timeout logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    tmo_d      = tmo_q;
    pc_valid_d = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        pc_d       = startPC;
        pend_vld_d = 1'b0;
        tmo_d      = '0;
        state_d    = is_aligned(startPC) ? ST_FETCH : ST_FAULT;
      end

      ST_FETCH: begin
        if (fetch_ack) begin
          // The acked fetch always reports completion, even if it then faults.
          pc_valid_d = 1'b1;
          pend_vld_d = 1'b0;
          tmo_d      = '0;
          if (mux_misaligned) begin
            state_d = ST_FAULT;
          end else begin
            pc_d = mux_next;
            if (halt_req)   state_d = ST_HALT;
            else if (stall) state_d = ST_HOLD;
            else            state_d = ST_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = ST_FAULT;
          pend_vld_d = 1'b0;
          tmo_d      = '0;
        end else if (halt_req) begin
          state_d    = ST_HALT;
          pend_vld_d = 1'b0;
          tmo_d      = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          // Latest redirect wins; jump outranks branch within a cycle.
          if (jump_valid || branch_valid) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = jump_valid ? jump_target : branch_target;
          end
        end
      end

      ST_HOLD: begin
        if (mux_misaligned) begin
          state_d = ST_FAULT;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else begin
          if (mux_redirect) pc_d = mux_next;
          if (!stall) state_d = ST_FETCH;
        end
      end

      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_FAULT;
    endcase
  end

  // State, PC and registered status outputs; reset dominates everything.
  always_ff @(posedge CLK) begin
    if (MasterReset) begin
      state_q     <= ST_BOOT;
      pc_q        <= '0;
      pend_vld_q  <= 1'b0;
      pend_tgt_q  <= '0;
      tmo_q       <= '0;
      fetch_req_q <= 1'b0;
      pc_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_tgt_q  <= pend_tgt_d;
      tmo_q       <= tmo_d;
      fetch_req_q <= (state_d == ST_FETCH);
      pc_valid_q  <= pc_valid_d;
      halted_q    <= (state_d == ST_HALT);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign PC        = pc_q;
  assign fetch_req = fetch_req_q;
  assign pc_valid  = pc_valid_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        MasterReset;
  logic [31:0] startPC;
  logic        stall;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        halt_req;
  logic        fetch_ack;
  logic [31:0] PC;
  logic        fetch_req;
  logic        pc_valid;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.TIMEOUT(15)) dut (
    .CLK           (CLK),
    .MasterReset   (MasterReset),
    .startPC       (startPC),
    .stall         (stall),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .fetch_ack     (fetch_ack),
    .PC            (PC),
    .fetch_req     (fetch_req),
    .pc_valid      (pc_valid),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all status outputs at once.
  task automatic chk_st(input string tag, input logic [31:0] pc_e, input logic fr_e,
                        input logic pv_e, input logic h_e, input logic f_e);
    chk({tag, ".PC"},        PC,                pc_e);
    chk({tag, ".fetch_req"}, {31'd0, fetch_req}, {31'd0, fr_e});
    chk({tag, ".pc_valid"},  {31'd0, pc_valid},  {31'd0, pv_e});
    chk({tag, ".halted"},    {31'd0, halted},    {31'd0, h_e});
    chk({tag, ".fault"},     {31'd0, fault},     {31'd0, f_e});
  endtask

  initial begin
    MasterReset = 1'b1; startPC = 32'h0; stall = 1'b0;
    jump_valid = 1'b0; jump_target = 32'h0;
    branch_valid = 1'b0; branch_target = 32'h0;
    halt_req = 1'b0; fetch_ack = 1'b0;

    // Reset state
    step();
    chk_st("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Boot and back-to-back fetches
    MasterReset = 1'b0; startPC = 32'h0040_0000; fetch_ack = 1'b1;
    step(); chk_st("boot", 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_st("seq1", 32'h0040_0004, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk_st("seq2", 32'h0040_0008, 1'b1, 1'b1, 1'b0, 1'b0);

    // Jump beats branch at ack
    jump_valid = 1'b1; jump_target = 32'h0040_0100;
    branch_valid = 1'b1; branch_target = 32'h0040_0200;
    step(); chk_st("jmp_prio", 32'h0040_0100, 1'b1, 1'b1, 1'b0, 1'b0);
    jump_valid = 1'b0; branch_valid = 1'b0;

    // Stall in ack cycle, branch redirect while holding, ack ignored in HOLD
    stall = 1'b1;
    step(); chk_st("hold0", 32'h0040_0104, 1'b0, 1'b1, 1'b0, 1'b0);
    branch_valid = 1'b1; branch_target = 32'h0040_0040;
    step(); chk_st("hold1", 32'h0040_0040, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_valid = 1'b0;
    step(); chk_st("hold2", 32'h0040_0040, 1'b0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_st("unhold", 32'h0040_0040, 1'b1, 1'b0, 1'b0, 1'b0);

    // Pending redirect: later overwrites earlier, pending beats live branch
    fetch_ack = 1'b0; branch_valid = 1'b1; branch_target = 32'h0040_0080;
    step(); chk_st("pend1", 32'h0040_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    branch_valid = 1'b0; jump_valid = 1'b1; jump_target = 32'h0040_0090;
    step(); chk_st("pend2", 32'h0040_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    jump_valid = 1'b0; fetch_ack = 1'b1;
    branch_valid = 1'b1; branch_target = 32'h0040_0300;
    step(); chk_st("pend_apply", 32'h0040_0090, 1'b1, 1'b1, 1'b0, 1'b0);
    branch_valid = 1'b0;

    // Wrap from 0xFFFFFFFC to 0
    jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
    step(); chk_st("to_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
    jump_valid = 1'b0;
    step(); chk_st("wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Fetch timeout: 14 silent cycles are fine, the 15th faults
    fetch_ack = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk_st("tmo14", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_st("tmo15", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_ack = 1'b1; halt_req = 1'b1; jump_valid = 1'b1; jump_target = 32'h0040_0000;
    step(); step(); step();
    chk_st("fault_sticky", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b0; jump_valid = 1'b0;

    // Reset clears fault
    MasterReset = 1'b1;
    step(); chk_st("reset2", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Misaligned jump target at ack: fault, PC kept, pc_valid still pulses
    MasterReset = 1'b0; startPC = 32'h0040_0000;
    step(); chk_st("boot2", 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    jump_valid = 1'b1; jump_target = 32'h0040_0102;
    step(); chk_st("misalign", 32'h0040_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    jump_valid = 1'b0;

    // Misaligned boot address faults directly
    MasterReset = 1'b1; step();
    MasterReset = 1'b0; startPC = 32'h0040_0002;
    step();
    chk("boot_mis.fault", {31'd0, fault}, 32'd1);
    chk("boot_mis.fetch_req", {31'd0, fetch_req}, 32'd0);

    // halt_req ignored in BOOT, then halt with simultaneous ack
    MasterReset = 1'b1; step();
    MasterReset = 1'b0; startPC = 32'h0040_0000; halt_req = 1'b1; fetch_ack = 1'b0;
    step(); chk_st("boot_halt", 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    fetch_ack = 1'b1;
    step();
    chk("halt_ack.pc_valid",  {31'd0, pc_valid},  32'd1);
    chk("halt_ack.halted",    {31'd0, halted},    32'd1);
    chk("halt_ack.fetch_req", {31'd0, fetch_req}, 32'd0);
    halt_req = 1'b0;
    step();
    chk("halt_hold.pc_valid", {31'd0, pc_valid}, 32'd0);
    chk("halt_hold.halted",   {31'd0, halted},   32'd1);

    // Reset mid-fetch aborts with no pc_valid
    MasterReset = 1'b1; step();
    MasterReset = 1'b0; fetch_ack = 1'b0;
    step(); chk_st("fetch_again", 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    fetch_ack = 1'b1; MasterReset = 1'b1;
    step(); chk_st("reset_mid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    MasterReset = 1'b0; fetch_ack = 1'b0;
    step(); chk_st("reboot", 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
